// File: rtl/zn_wlx_fsk_pkg.sv
// Shared definitions for the FSK front-end blocks: crossing FSM state encoding and
// threshold sanity check.
package zn_wlx_fsk_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_ARMED    = 2'd1,
        S_HIGH     = 2'd2,
        S_LOW      = 2'd3
    } state_e;

    function automatic bit thr_ok(input int unsigned lo, input int unsigned hi);
        return lo < hi;
    endfunction

endpackage

// File: rtl/zn_wlx_period_avg.sv
// Accumulates 2^AVG_LOG2 period samples and presents their truncated mean together with
// a strobe on the sample that completes the window.
module zn_wlx_period_avg
    import zn_wlx_fsk_pkg::*;
#(
    parameter int unsigned CW       = 16,
    parameter int unsigned AVG_LOG2 = 0
) (
    input  logic          sample_clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          sample_valid,
    input  logic [CW-1:0] sample,
    output logic [CW-1:0] result,
    output logic          done
);

    localparam int unsigned AW = CW + AVG_LOG2;
    // Keep the window counter at least one bit wide so AVG_LOG2 = 0 still elaborates.
    localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NW-1:0] LAST = NW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc;
    logic [NW-1:0] avg_cnt;
    logic [AW-1:0] sum;

    assign sum    = acc + AW'(sample);
    assign done   = sample_valid && !clear && (avg_cnt == LAST);
    assign result = CW'(sum >> AVG_LOG2);

    always_ff @(posedge sample_clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (clear || done) begin
            acc     <= '0;
            avg_cnt <= '0;
        end else if (sample_valid) begin
            acc     <= sum;
            avg_cnt <= avg_cnt + NW'(1);
        end
    end

endmodule

// File: rtl/zn_wlx_period_meter.sv
// Hysteresis period meter: counts sample_clk cycles between qualified rising crossings,
// averages them and flags loss of signal after a timeout.
module zn_wlx_period_meter
    import zn_wlx_fsk_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned THR_HI   = 150,
    parameter int unsigned THR_LO   = 100,
    parameter int unsigned CW       = 16,
    parameter int unsigned AVG_LOG2 = 0,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic          sample_clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] data_in,
    output logic [CW-1:0] period_out,
    output logic          period_valid,
    output logic          signal_lost
);

    if (!thr_ok(THR_LO, THR_HI)) begin : g_bad_thr
        $error("zn_wlx_period_meter: THR_LO must be below THR_HI");
    end
    if (TIMEOUT < 2 || 64'(TIMEOUT) > ((64'd1 << CW) - 64'd1)) begin : g_bad_timeout
        $error("zn_wlx_period_meter: TIMEOUT out of range for CW");
    end

    localparam logic [DW-1:0] THR_HI_V  = DW'(THR_HI);
    localparam logic [DW-1:0] THR_LO_V  = DW'(THR_LO);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          rise;
    logic          fall;
    logic          counting;
    logic          crossing;
    logic          timeout;
    logic          sample_stb;
    logic          avg_clear;
    logic [CW-1:0] avg_result;
    logic          avg_done;

    assign rise     = data_in >= THR_HI_V;
    assign fall     = data_in <= THR_LO_V;
    assign counting = (state == S_HIGH) || (state == S_LOW);
    assign crossing = ((state == S_HIGH) && fall) || ((state == S_LOW) && rise);
    // A crossing on the timeout edge takes precedence, so cnt may briefly pass TIMEOUT.
    assign timeout  = en && counting && !crossing && (cnt >= TIMEOUT_V);
    assign sample_stb = en && (state == S_LOW) && rise;
    assign avg_clear  = !en || timeout;
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + CW'(1);

    zn_wlx_period_avg #(
        .CW       (CW),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .sample_clk   (sample_clk),
        .rst          (rst),
        .clear        (avg_clear),
        .sample_valid (sample_stb),
        .sample       (cnt),
        .result       (avg_result),
        .done         (avg_done)
    );

    always_ff @(posedge sample_clk or negedge rst) begin
        if (!rst) begin
            state        <= S_WAIT_LOW;
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!en) begin
                state <= S_WAIT_LOW;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_WAIT_LOW: begin
                        if (fall) state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (rise) begin
                            cnt   <= CW'(1);
                            state <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (timeout) begin
                            cnt   <= '0;
                            state <= S_WAIT_LOW;
                        end else begin
                            cnt <= cnt_inc;
                            if (fall) state <= S_LOW;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            cnt   <= CW'(1);
                            state <= S_HIGH;
                        end else if (timeout) begin
                            cnt   <= '0;
                            state <= S_WAIT_LOW;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= S_WAIT_LOW;
                endcase

                if (timeout) begin
                    signal_lost <= 1'b1;
                    period_out  <= '0;
                end else if (avg_done) begin
                    period_out   <= avg_result;
                    period_valid <= 1'b1;
                    signal_lost  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_zn_wlx_period_meter.sv
// Directed bench for zn_wlx_period_meter: table of 4-period windows plus hand-written
// sequences for back-to-back windows, timeout, asynchronous reset and enable drop.
module tb_zn_wlx_period_meter;

    logic        sample_clk;
    logic        rst;
    logic        en;
    logic [7:0]  data_in;
    logic [15:0] period_out;
    logic        period_valid;
    logic        signal_lost;

    int unsigned checks;
    int unsigned errors;
    int unsigned nvalid;

    typedef struct {
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] p3;
        bit          noise;
        int unsigned pre;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    zn_wlx_period_meter #(
        .DW       (8),
        .THR_HI   (150),
        .THR_LO   (100),
        .CW       (16),
        .AVG_LOG2 (2),
        .TIMEOUT  (1000)
    ) dut (
        .sample_clk   (sample_clk),
        .rst          (rst),
        .en           (en),
        .data_in      (data_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .signal_lost  (signal_lost)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            data_in = v;
            @(posedge sample_clk);
            #1;
            if (period_valid) nvalid++;
        end
    endtask

    task automatic drive_noise();
        for (int i = 0; i < 10; i++) drive(8'(101 + 5 * i), 1);
    endtask

    task automatic do_reset(input logic [7:0] d);
        data_in = d;
        rst     = 1'b0;
        repeat (2) @(posedge sample_clk);
        #1;
        rst = 1'b1;
    endtask

    // Low lead-in, four periods (high half first), then the rising edge closing the window.
    task automatic run_window(input vec_t v, input logic [15:0] hold, input string tag);
        int unsigned p[4];
        int unsigned hi;
        int unsigned lo;
        p[0] = v.p0; p[1] = v.p1; p[2] = v.p2; p[3] = v.p3;
        nvalid = 0;
        drive(8'd0, 5);
        for (int k = 0; k < 4; k++) begin
            hi = (p[k] + 1) / 2;
            lo = p[k] / 2;
            if (v.noise) begin
                drive(8'd200, 5); drive_noise(); drive(8'd200, hi - 15);
                drive(8'd0, 5);   drive_noise(); drive(8'd0, lo - 15);
            end else begin
                drive(8'd200, hi);
                drive(8'd0, lo);
            end
        end
        check({tag, " early_valid"}, nvalid, 0);
        check({tag, " hold_out"}, period_out, hold);
        drive(8'd200, 1);
        check({tag, " valid"}, period_valid, 1);
        check({tag, " period"}, period_out, v.exp);
        check({tag, " lost"}, signal_lost, 0);
    endtask

    function automatic vec_t mk(input int unsigned a, input int unsigned b, input int unsigned c,
                                input int unsigned d, input bit nz, input int unsigned pre,
                                input int unsigned e);
        vec_t v;
        v.p0 = 16'(a); v.p1 = 16'(b); v.p2 = 16'(c); v.p3 = 16'(d);
        v.noise = nz; v.pre = pre; v.exp = 16'(e);
        return v;
    endfunction

    initial begin
        vec_t sq40;
        checks  = 0;
        errors  = 0;
        nvalid  = 0;
        rst     = 1'b0;
        en      = 1'b1;
        data_in = 8'd0;

        vecs[0] = mk(40, 40, 40, 40, 0, 0, 40);
        vecs[1] = mk(40, 41, 40, 41, 0, 0, 40);
        vecs[2] = mk(41, 41, 41, 43, 0, 0, 41);
        vecs[3] = mk(40, 40, 40, 40, 1, 0, 40);
        vecs[4] = mk(20, 20, 20, 20, 0, 50, 20);
        vecs[5] = mk(3, 4, 5, 100, 0, 0, 28);
        vecs[6] = mk(2, 2, 2, 3, 0, 0, 2);
        sq40    = vecs[0];

        repeat (2) @(posedge sample_clk);
        #1;
        check("reset outputs", {period_out, period_valid, signal_lost}, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset((vecs[i].pre > 0) ? 8'd200 : 8'd0);
            drive(8'd200, vecs[i].pre);
            run_window(vecs[i], 16'd0, $sformatf("vec%0d", i));
        end

        // Back-to-back window: next pulse 160 cycles after the previous one.
        do_reset(8'd0);
        run_window(sq40, 16'd0, "seqA first");
        nvalid = 0;
        drive(8'd200, 19);
        drive(8'd0, 20);
        for (int k = 0; k < 3; k++) begin
            drive(8'd200, 20);
            drive(8'd0, 20);
        end
        check("seqA no_early", nvalid, 0);
        drive(8'd200, 1);
        check("seqA valid", period_valid, 1);
        check("seqA period", period_out, 40);

        // Stuck high: loss of signal exactly 1000 cycles after the last rising crossing.
        nvalid = 0;
        drive(8'd200, 999);
        check("seqB lost_before", signal_lost, 0);
        check("seqB out_before", period_out, 40);
        drive(8'd200, 1);
        check("seqB lost", signal_lost, 1);
        check("seqB out_zero", period_out, 0);
        check("seqB no_valid", nvalid, 0);
        drive(8'd200, 30);
        check("seqB lost_holds", signal_lost, 1);
        run_window(sq40, 16'd0, "seqB resume");

        // Asynchronous reset mid-window with a partial sum pending.
        drive(8'd200, 19);
        drive(8'd0, 20);
        drive(8'd200, 20);
        drive(8'd0, 10);
        #2;
        rst = 1'b0;
        #1;
        check("seqC async_out", period_out, 0);
        check("seqC async_flags", {period_valid, signal_lost}, 0);
        @(posedge sample_clk);
        #1;
        rst = 1'b1;
        run_window(vecs[4], 16'd0, "seqC restart");

        // Enable drop mid-window: partial window discarded, period_out holds.
        drive(8'd200, 9);
        drive(8'd0, 10);
        drive(8'd200, 20);
        drive(8'd0, 10);
        nvalid = 0;
        en = 1'b0;
        drive(8'd0, 5);
        en = 1'b1;
        check("seqD en_hold_out", period_out, 20);
        check("seqD en_no_valid", nvalid, 0);
        run_window(mk(30, 30, 30, 30, 0, 0, 30), 16'd20, "seqD rearm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
